route_update_engine: RTL and testbench
======================================

ROUTE_UPDATE_ENGINE -- requirements
Module: route_update_engine

Interface
REQ-001 Parameters SHALL be, one per line:
- WORD_WIDTH, 16, data and address width.
- MAX_NEIGHBORS, 16, routing-table rows.
- MAX_SINKS, 8, sink-ID slots per row; row stride 2*MAX_SINKS bytes.
- KSINK_BASE, 16'h008, knownSinks array base.
- NBR_ID_BASE, 16'h048, neighborID array base; clusterID +16'h80, batteryStat +16'h100, qValue +16'h180, sinkIDs +16'h200.
- KSINK_CNT_ADDR, 16'h688, knownSinkCount word.
- NBR_CNT_ADDR, 16'h68A, neighborCount word.
- SINKCNT_BASE, 16'h68E, per-row sinkIDCount array base.
REQ-002 Ports SHALL be:
- clock, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, request; sampled only in IDLE.
- fsourceID, fbatteryStat, fValue, fclusterID, in, WORD_WIDTH each, received-packet fields; latched on accepted start.
- data_in, in, WORD_WIDTH, memory read data; valid the cycle after address is driven.
- address, out, WORD_WIDTH, byte address; word arrays stride 2.
- wr_en, out, 1, write strobe for current address/data_out.
- data_out, out, WORD_WIDTH, write data.
- busy, out, 1, high from the cycle after accepted start until done.
- done, out, 1, one-cycle completion pulse.
- reinit, out, 1, valid with done; held until next accepted start.
- full, out, 1, valid with done; new neighbor dropped.
- nbr_index, out, WORD_WIDTH, row updated or appended; valid with done.

Function
REQ-003 FSM SHALL be IDLE, RD_NCNT, RD_KCNT, SCAN, CHK, UPD_SINK, UPD_ROW, ADD_ROW, ADD_SINK, WR_NCNT, DONE.
REQ-004 IDLE: start=1 latches f* fields, clears n, k, reinit, full, moves to RD_NCNT; start while busy SHALL be ignored.
REQ-005 RD_NCNT/RD_KCNT: read NBR_CNT_ADDR and KSINK_CNT_ADDR; stored counts SHALL be clamped to MAX_NEIGHBORS and MAX_SINKS.
REQ-006 SCAN/CHK: for n=0..neighborCount-1 read NBR_ID_BASE+2n (2 cycles per entry); first match -> UPD_SINK with nbr_index=n; no match -> ADD_ROW, or DONE with full=1 if neighborCount==MAX_NEIGHBORS (no writes).
REQ-007 UPD_SINK/ADD_SINK: for k=0..knownSinkCount-1 read KSINK_BASE+2k, write value to sinkIDs row base+2k; then write k to SINKCNT_BASE+2*nbr_index.
REQ-008 UPD_ROW (existing): write fbatteryStat to batteryStat[n]; read old qValue; reinit=1 iff old qValue < fValue (unsigned); write fValue to qValue[n].
REQ-009 ADD_ROW (new, n=neighborCount): write fsourceID, fclusterID, fbatteryStat, fValue to their arrays; reinit=0; then ADD_SINK, then WR_NCNT writes neighborCount+1 to NBR_CNT_ADDR.
REQ-010 wr_en SHALL be high exactly one cycle per write, never coinciding with a read whose data is used.
REQ-011 DONE: pulse done one cycle, drop busy, return to IDLE; start in the same cycle as done SHALL be ignored.
REQ-012 Address arithmetic SHALL truncate to WORD_WIDTH; knownSinkCount=0 SHALL write sinkIDCount=0 with no sinkID writes.

Reset
REQ-013 rst SHALL force IDLE; address, data_out, nbr_index to 0; wr_en, busy, done, reinit, full to 0.
REQ-014 rst mid-operation SHALL abort within one cycle with no further writes; partial writes are not rolled back.

Configuration
REQ-015 With CLUSTER_WRITEBACK_EN defined, UPD_ROW SHALL also write fclusterID to clusterID[n] before batteryStat; without it, clusterID of existing rows SHALL never be written.

Verification
REQ-016 Match: neighborCount=3, IDs {5,9,7}, fsourceID=9, knownSinkCount=2 sinks {1,4}, old q=10, fValue=20 -> sinkIDs row1={1,4}, sinkIDCount[1]=2, q[1]=20, reinit=1, nbr_index=1, done once.
REQ-017 No match: neighborCount=2, fsourceID=12 -> row 2 written with all fields, neighborCount=3, reinit=0, full=0.
REQ-018 Full: neighborCount=MAX_NEIGHBORS, no match -> zero writes, full=1, done pulse.
REQ-019 Reset during ADD_SINK -> next cycle wr_en=0, busy=0, state IDLE; next start runs normally.
REQ-020 Back-to-back: start held high -> second update begins only after done, IDLE observed one cycle; old q=30, fValue=20 -> reinit=0.

Source files
------------

// File: rtl/route_update_engine.sv
// route_update_engine
// Applies one received routing packet to a memory-resident routing table.
// It reads the neighbor and known-sink counts, scans the neighborID array,
// and then either refreshes an existing row or appends a new one.
// Every memory read takes two cycles: the address is driven, then data_in is used.
// Optional feature macro: CLUSTER_WRITEBACK_EN. When it is defined, refreshing an
// existing row also rewrites its clusterID entry.
module route_update_engine #(
  parameter int WORD_WIDTH    = 16,
  parameter int MAX_NEIGHBORS = 16,
  parameter int MAX_SINKS     = 8,
  parameter logic [WORD_WIDTH-1:0] KSINK_BASE     = 16'h0008,
  parameter logic [WORD_WIDTH-1:0] NBR_ID_BASE    = 16'h0048,
  parameter logic [WORD_WIDTH-1:0] KSINK_CNT_ADDR = 16'h0688,
  parameter logic [WORD_WIDTH-1:0] NBR_CNT_ADDR   = 16'h068A,
  parameter logic [WORD_WIDTH-1:0] SINKCNT_BASE   = 16'h068E
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] fsourceID,
  input  logic [WORD_WIDTH-1:0] fbatteryStat,
  input  logic [WORD_WIDTH-1:0] fValue,
  input  logic [WORD_WIDTH-1:0] fclusterID,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  reinit,
  output logic                  full,
  output logic [WORD_WIDTH-1:0] nbr_index
);

  localparam logic [WORD_WIDTH-1:0] MAX_N_W      = WORD_WIDTH'(MAX_NEIGHBORS);
  localparam logic [WORD_WIDTH-1:0] MAX_S_W      = WORD_WIDTH'(MAX_SINKS);
  localparam logic [WORD_WIDTH-1:0] ONE_W        = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] ROW_STRIDE   = WORD_WIDTH'(MAX_SINKS + MAX_SINKS);
  localparam logic [WORD_WIDTH-1:0] CLUSTER_BASE = NBR_ID_BASE + WORD_WIDTH'(16'h0080);
  localparam logic [WORD_WIDTH-1:0] BAT_BASE     = NBR_ID_BASE + WORD_WIDTH'(16'h0100);
  localparam logic [WORD_WIDTH-1:0] Q_BASE       = NBR_ID_BASE + WORD_WIDTH'(16'h0180);
  localparam logic [WORD_WIDTH-1:0] SINKID_BASE  = NBR_ID_BASE + WORD_WIDTH'(16'h0200);

  typedef enum logic [3:0] {
    IDLE, RD_NCNT, RD_KCNT, SCAN, CHK, UPD_SINK, UPD_ROW, ADD_ROW, ADD_SINK, WR_NCNT, DONE
  } state_t;

  state_t                state_r;
  logic [2:0]            ph_r;       // sub-step inside multi-cycle states
  logic [WORD_WIDTH-1:0] n_r;
  logic [WORD_WIDTH-1:0] k_r;
  logic [WORD_WIDTH-1:0] ncnt_r;
  logic [WORD_WIDTH-1:0] kcnt_r;
  logic [WORD_WIDTH-1:0] fsrc_r;
  logic [WORD_WIDTH-1:0] fbat_r;
  logic [WORD_WIDTH-1:0] fval_r;
  logic [WORD_WIDTH-1:0] fcl_r;

  logic [WORD_WIDTH-1:0] ncnt_clamp_s;
  logic [WORD_WIDTH-1:0] kcnt_clamp_s;
  logic [WORD_WIDTH-1:0] n_next_s;
  logic [WORD_WIDTH-1:0] k_next_s;
  logic [WORD_WIDTH-1:0] row_base_s;

  // Byte address of element idx in a word array; wraps at WORD_WIDTH.
  function automatic logic [WORD_WIDTH-1:0] word_addr(input logic [WORD_WIDTH-1:0] base,
                                                      input logic [WORD_WIDTH-1:0] idx);
    return base + {idx[WORD_WIDTH-2:0], 1'b0};
  endfunction

  assign ncnt_clamp_s = (data_in > MAX_N_W) ? MAX_N_W : data_in;
  assign kcnt_clamp_s = (data_in > MAX_S_W) ? MAX_S_W : data_in;
  assign n_next_s     = n_r + ONE_W;
  assign k_next_s     = k_r + ONE_W;
  assign row_base_s   = SINKID_BASE + (nbr_index * ROW_STRIDE);

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r   <= IDLE;
      ph_r      <= 3'd0;
      n_r       <= '0;
      k_r       <= '0;
      ncnt_r    <= '0;
      kcnt_r    <= '0;
      fsrc_r    <= '0;
      fbat_r    <= '0;
      fval_r    <= '0;
      fcl_r     <= '0;
      address   <= '0;
      data_out  <= '0;
      nbr_index <= '0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      reinit    <= 1'b0;
      full      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done  <= 1'b0;
          wr_en <= 1'b0;
          if (start) begin
            fsrc_r  <= fsourceID;
            fbat_r  <= fbatteryStat;
            fval_r  <= fValue;
            fcl_r   <= fclusterID;
            n_r     <= '0;
            k_r     <= '0;
            reinit  <= 1'b0;
            full    <= 1'b0;
            busy    <= 1'b1;
            address <= NBR_CNT_ADDR;
            ph_r    <= 3'd0;
            state_r <= RD_NCNT;
          end
        end
        RD_NCNT: begin
          if (ph_r == 3'd0) begin
            ph_r <= 3'd1;
          end else begin
            ncnt_r  <= ncnt_clamp_s;
            address <= KSINK_CNT_ADDR;
            ph_r    <= 3'd0;
            state_r <= RD_KCNT;
          end
        end
        RD_KCNT: begin
          if (ph_r == 3'd0) begin
            ph_r <= 3'd1;
          end else begin
            kcnt_r <= kcnt_clamp_s;
            n_r    <= '0;
            ph_r   <= 3'd0;
            if (ncnt_r == '0) begin
              // empty table: nothing to scan, append as row 0
              nbr_index <= '0;
              state_r   <= ADD_ROW;
            end else begin
              address <= NBR_ID_BASE;
              state_r <= SCAN;
            end
          end
        end
        SCAN: begin
          state_r <= CHK;
        end
        CHK: begin
          if (data_in == fsrc_r) begin
            nbr_index <= n_r;
            k_r       <= '0;
            ph_r      <= 3'd0;
            state_r   <= UPD_SINK;
          end else if (n_next_s < ncnt_r) begin
            n_r     <= n_next_s;
            address <= word_addr(NBR_ID_BASE, n_next_s);
            state_r <= SCAN;
          end else if (ncnt_r == MAX_N_W) begin
            full    <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else begin
            nbr_index <= ncnt_r;
            ph_r      <= 3'd0;
            state_r   <= ADD_ROW;
          end
        end
        UPD_SINK, ADD_SINK: begin
          // copy knownSinks into the row, then record how many were copied
          case (ph_r)
            3'd0: begin
              if (kcnt_r == '0) begin
                address  <= word_addr(SINKCNT_BASE, nbr_index);
                data_out <= '0;
                wr_en    <= 1'b1;
                ph_r     <= 3'd4;
              end else begin
                address <= word_addr(KSINK_BASE, k_r);
                ph_r    <= 3'd1;
              end
            end
            3'd1: ph_r <= 3'd2;
            3'd2: begin
              address  <= word_addr(row_base_s, k_r);
              data_out <= data_in;
              wr_en    <= 1'b1;
              ph_r     <= 3'd3;
            end
            3'd3: begin
              k_r <= k_next_s;
              if (k_next_s < kcnt_r) begin
                wr_en   <= 1'b0;
                address <= word_addr(KSINK_BASE, k_next_s);
                ph_r    <= 3'd1;
              end else begin
                address  <= word_addr(SINKCNT_BASE, nbr_index);
                data_out <= k_next_s;
                wr_en    <= 1'b1;
                ph_r     <= 3'd4;
              end
            end
            3'd4: begin
              wr_en   <= 1'b0;
              ph_r    <= 3'd0;
              state_r <= (state_r == UPD_SINK) ? UPD_ROW : WR_NCNT;
            end
            default: ph_r <= 3'd0;
          endcase
        end
        UPD_ROW: begin
          // refresh battery, compare and replace qValue
          case (ph_r)
            3'd0: begin
`ifdef CLUSTER_WRITEBACK_EN
              address  <= word_addr(CLUSTER_BASE, nbr_index);
              data_out <= fcl_r;
              wr_en    <= 1'b1;
              ph_r     <= 3'd5;
`else
              address  <= word_addr(BAT_BASE, nbr_index);
              data_out <= fbat_r;
              wr_en    <= 1'b1;
              ph_r     <= 3'd1;
`endif
            end
            3'd5: begin
              address  <= word_addr(BAT_BASE, nbr_index);
              data_out <= fbat_r;
              wr_en    <= 1'b1;
              ph_r     <= 3'd1;
            end
            3'd1: begin
              wr_en   <= 1'b0;
              address <= word_addr(Q_BASE, nbr_index);
              ph_r    <= 3'd2;
            end
            3'd2: ph_r <= 3'd3;
            3'd3: begin
              reinit   <= (data_in < fval_r);
              data_out <= fval_r;
              wr_en    <= 1'b1;
              ph_r     <= 3'd4;
            end
            3'd4: begin
              wr_en   <= 1'b0;
              done    <= 1'b1;
              busy    <= 1'b0;
              ph_r    <= 3'd0;
              state_r <= DONE;
            end
            default: ph_r <= 3'd0;
          endcase
        end
        ADD_ROW: begin
          // four back-to-back writes fill the new row's scalar fields
          case (ph_r)
            3'd0: begin
              address  <= word_addr(NBR_ID_BASE, nbr_index);
              data_out <= fsrc_r;
              wr_en    <= 1'b1;
              ph_r     <= 3'd1;
            end
            3'd1: begin
              address  <= word_addr(CLUSTER_BASE, nbr_index);
              data_out <= fcl_r;
              ph_r     <= 3'd2;
            end
            3'd2: begin
              address  <= word_addr(BAT_BASE, nbr_index);
              data_out <= fbat_r;
              ph_r     <= 3'd3;
            end
            3'd3: begin
              address  <= word_addr(Q_BASE, nbr_index);
              data_out <= fval_r;
              ph_r     <= 3'd4;
            end
            3'd4: begin
              wr_en   <= 1'b0;
              k_r     <= '0;
              ph_r    <= 3'd0;
              state_r <= ADD_SINK;
            end
            default: ph_r <= 3'd0;
          endcase
        end
        WR_NCNT: begin
          if (ph_r == 3'd0) begin
            address  <= NBR_CNT_ADDR;
            data_out <= ncnt_r + ONE_W;
            wr_en    <= 1'b1;
            ph_r     <= 3'd1;
          end else begin
            wr_en   <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            ph_r    <= 3'd0;
            state_r <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          wr_en   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          ph_r    <= 3'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_route_update_engine.sv
// Self-checking bench for route_update_engine: a word memory model, a reference
// model that predicts the table image and done-time outputs, and a scoreboard.
module tb_route_update_engine;

  logic        clock;
  logic        rst;
  logic        start;
  logic [15:0] fsourceID, fbatteryStat, fValue, fclusterID;
  logic [15:0] data_in;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] data_out;
  logic        busy, done, reinit, full;
  logic [15:0] nbr_index;

  route_update_engine dut (
    .clock(clock), .rst(rst), .start(start),
    .fsourceID(fsourceID), .fbatteryStat(fbatteryStat), .fValue(fValue), .fclusterID(fclusterID),
    .data_in(data_in), .address(address), .wr_en(wr_en), .data_out(data_out),
    .busy(busy), .done(done), .reinit(reinit), .full(full), .nbr_index(nbr_index)
  );

  typedef struct packed {
    logic        reinit;
    logic        full;
    logic        chk_idx;
    logic [15:0] idx;
    int          writes;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mem     [0:1023];
  logic [15:0] exp_mem [0:1023];
  int          checks = 0;
  int          errors = 0;
  int          wr_total = 0;
  int          wr_mark = 0;
  logic        poke_en, mem_clear;
  logic [15:0] poke_addr, poke_data;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory model: one-cycle read latency, writes on wr_en, bench pokes when idle
  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
    end else if (poke_en) begin
      mem[poke_addr[10:1]] <= poke_data;
    end else if (wr_en) begin
      mem[address[10:1]] <= data_out;
    end
    data_in <= mem[address[10:1]];
  end

  // count every write strobe
  always @(posedge clock) begin
    if (wr_en) wr_total = wr_total + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: compare done-time outputs with the predicted ones
  always @(negedge clock) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("reinit", {31'd0, reinit}, {31'd0, e.reinit});
        check_val("full", {31'd0, full}, {31'd0, e.full});
        if (e.chk_idx) check_val("nbr_index", {16'd0, nbr_index}, {16'd0, e.idx});
        check_val("write count", wr_total - wr_mark, e.writes);
      end
    end
  end

  function automatic logic [15:0] rdm(input logic [15:0] a);
    return mem[a[10:1]];
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) exp_mem[i] = 16'h0000;
    mem_clear = 1'b1;
    @(negedge clock);
    mem_clear = 1'b0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    exp_mem[a[10:1]] = v;
    poke_addr = a;
    poke_data = v;
    poke_en   = 1'b1;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  function automatic logic [15:0] ea(input logic [15:0] base, input int idx);
    logic [15:0] r;
    r = base + 16'(2 * idx);
    return r;
  endfunction

  // reference model: apply one update to exp_mem and queue the expected outputs
  task automatic model_op(input logic [15:0] fs, input logic [15:0] fb,
                          input logic [15:0] fv, input logic [15:0] fc);
    int   nc, kc, idx;
    bit   found;
    exp_t e;
    logic [15:0] a;
    nc = int'(exp_mem[11'h68A >> 1]);
    kc = int'(exp_mem[11'h688 >> 1]);
    if (nc > 16) nc = 16;
    if (kc > 8) kc = 8;
    found = 1'b0;
    idx = 0;
    for (int n = 0; n < nc; n++) begin
      a = ea(16'h0048, n);
      if (!found && exp_mem[a[10:1]] == fs) begin found = 1'b1; idx = n; end
    end
    e.reinit = 1'b0; e.full = 1'b0; e.chk_idx = 1'b1; e.writes = 0;
    if (!found && nc == 16) begin
      e.full = 1'b1; e.chk_idx = 1'b0; e.idx = 16'h0000;
    end else begin
      if (!found) begin
        idx = nc;
        a = ea(16'h0048, idx); exp_mem[a[10:1]] = fs;
        a = ea(16'h00C8, idx); exp_mem[a[10:1]] = fc;
        a = ea(16'h0148, idx); exp_mem[a[10:1]] = fb;
        a = ea(16'h01C8, idx); exp_mem[a[10:1]] = fv;
        a = 16'h068A;          exp_mem[a[10:1]] = 16'(nc + 1);
        e.writes = 5;
      end
      for (int k = 0; k < kc; k++) begin
        logic [15:0] s;
        s = ea(16'h0008, k);
        a = ea(16'h0248, idx * 8 + k);
        exp_mem[a[10:1]] = exp_mem[s[10:1]];
      end
      a = ea(16'h068E, idx); exp_mem[a[10:1]] = 16'(kc);
      e.writes = e.writes + kc + 1;
      if (found) begin
`ifdef CLUSTER_WRITEBACK_EN
        a = ea(16'h00C8, idx); exp_mem[a[10:1]] = fc;
        e.writes = e.writes + 1;
`endif
        a = ea(16'h0148, idx); exp_mem[a[10:1]] = fb;
        a = ea(16'h01C8, idx);
        e.reinit = (exp_mem[a[10:1]] < fv);
        exp_mem[a[10:1]] = fv;
        e.writes = e.writes + 2;
      end
      e.idx = 16'(idx);
    end
    sb_q.push_back(e);
  endtask

  task automatic compare_mem(input string tag);
    int diffs, first;
    diffs = 0; first = -1;
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== exp_mem[i]) begin
        if (first < 0) first = i;
        diffs++;
      end
    end
    if (diffs != 0) $display("note: %s first differing byte address %0h", tag, first * 2);
    check_val(tag, diffs, 0);
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!done && cyc < 3000) begin @(negedge clock); cyc++; end
    if (!done) check_val({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] fs, input logic [15:0] fb,
                        input logic [15:0] fv, input logic [15:0] fc, input bit pulse);
    model_op(fs, fb, fv, fc);
    fsourceID = fs; fbatteryStat = fb; fValue = fv; fclusterID = fc;
    wr_mark = wr_total;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_val({tag, " busy"}, {31'd0, busy}, 32'd1);
    if (pulse) begin
      repeat (3) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    wait_done(tag);
    @(negedge clock);
    check_val({tag, " done width"}, {31'd0, done}, 32'd0);
    check_val({tag, " busy after"}, {31'd0, busy}, 32'd0);
    compare_mem({tag, " image"});
  endtask

  task automatic setup_table(input int nc, input int kc);
    clear_mem();
    poke(16'h068A, 16'(nc));
    poke(16'h0688, 16'(kc));
  endtask

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; poke_en = 1'b0; mem_clear = 1'b0;
    poke_addr = 16'h0000; poke_data = 16'h0000;
    fsourceID = 16'h0000; fbatteryStat = 16'h0000; fValue = 16'h0000; fclusterID = 16'h0000;
    repeat (3) @(negedge clock);
    check_val("rst address", {16'd0, address}, 32'd0);
    check_val("rst data_out", {16'd0, data_out}, 32'd0);
    check_val("rst nbr_index", {16'd0, nbr_index}, 32'd0);
    check_val("rst flags", {27'd0, wr_en, busy, done, reinit, full}, 32'd0);
    rst = 1'b0;

    // match on row 1, old q=10 < 20; extra start pulse mid-operation is ignored
    setup_table(3, 2);
    poke(16'h0048, 16'd5); poke(16'h004A, 16'd9); poke(16'h004C, 16'd7);
    poke(16'h0008, 16'd1); poke(16'h000A, 16'd4);
    poke(16'h01CA, 16'd10); poke(16'h00CA, 16'h00AA);
    run_op("match", 16'd9, 16'h0055, 16'd20, 16'h0077, 1'b1);
    check_val("match sink0", {16'd0, rdm(16'h0258)}, 32'd1);
    check_val("match sink1", {16'd0, rdm(16'h025A)}, 32'd4);
    check_val("match sinkcnt", {16'd0, rdm(16'h0690)}, 32'd2);
    check_val("match q", {16'd0, rdm(16'h01CA)}, 32'd20);

    // no match: append row 2
    setup_table(2, 2);
    poke(16'h0048, 16'd5); poke(16'h004A, 16'd9);
    poke(16'h0008, 16'd3); poke(16'h000A, 16'd6);
    run_op("append", 16'd12, 16'h0031, 16'd40, 16'h0022, 1'b0);
    check_val("append id", {16'd0, rdm(16'h004C)}, 32'd12);
    check_val("append ncnt", {16'd0, rdm(16'h068A)}, 32'd3);

    // full table, no match
    setup_table(16, 2);
    for (int i = 0; i < 16; i++) poke(ea(16'h0048, i), 16'(100 + i));
    run_op("full", 16'd3, 16'h0001, 16'd2, 16'h0004, 1'b0);

    // stored neighborCount above the limit is clamped; slot 16 must not be scanned
    setup_table(20, 1);
    for (int i = 0; i < 16; i++) poke(ea(16'h0048, i), 16'(200 + i));
    poke(16'h0068, 16'd77);
    run_op("clamp ncnt", 16'd77, 16'h0001, 16'd2, 16'h0004, 1'b0);

    // zero known sinks: count written as 0, no sinkID writes
    setup_table(1, 0);
    poke(16'h0048, 16'd33); poke(16'h01C8, 16'd5); poke(16'h068E, 16'd7);
    poke(16'h0248, 16'h1234);
    run_op("zero sinks", 16'd33, 16'h0009, 16'd6, 16'h0002, 1'b0);
    check_val("zero sinkcnt", {16'd0, rdm(16'h068E)}, 32'd0);

    // stored knownSinkCount above the limit is clamped to 8
    setup_table(4, 10);
    for (int i = 0; i < 4; i++) poke(ea(16'h0048, i), 16'(i + 1));
    for (int k = 0; k < 10; k++) poke(ea(16'h0008, k), 16'(16'h0300 + k));
    run_op("clamp kcnt", 16'd50, 16'h0011, 16'd9, 16'h0003, 1'b0);
    check_val("clamp sinkcnt", {16'd0, rdm(16'h0696)}, 32'd8);

    // reset in the middle of the sink copy of an append
    setup_table(2, 3);
    poke(16'h0048, 16'd5); poke(16'h004A, 16'd9);
    poke(16'h0008, 16'd1); poke(16'h000A, 16'd2); poke(16'h000C, 16'd3);
    model_op(16'd12, 16'h0001, 16'd8, 16'h0002);
    fsourceID = 16'd12; fbatteryStat = 16'h0001; fValue = 16'd8; fclusterID = 16'h0002;
    wr_mark = wr_total;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while ((wr_total - wr_mark) < 5 && cyc < 500) begin @(negedge clock); cyc++; end
      check_val("reach sink copy", {31'd0, ((wr_total - wr_mark) >= 5)}, 32'd1);
    end
    rst = 1'b1;
    @(negedge clock);
    check_val("abort wr_en", {31'd0, wr_en}, 32'd0);
    check_val("abort busy", {31'd0, busy}, 32'd0);
    check_val("abort done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    sb_q.delete();
    w = wr_total;
    repeat (6) @(negedge clock);
    check_val("no writes after abort", wr_total, w);
    setup_table(2, 3);
    poke(16'h0048, 16'd5); poke(16'h004A, 16'd9);
    poke(16'h0008, 16'd1); poke(16'h000A, 16'd2); poke(16'h000C, 16'd3);
    run_op("after reset", 16'd12, 16'h0001, 16'd8, 16'h0002, 1'b0);

    // back-to-back with start held high: old q=30, fValue=20
    setup_table(3, 2);
    poke(16'h0048, 16'd5); poke(16'h004A, 16'd9); poke(16'h004C, 16'd7);
    poke(16'h0008, 16'd1); poke(16'h000A, 16'd4); poke(16'h01CC, 16'd30);
    model_op(16'd7, 16'h0005, 16'd20, 16'h0006);
    model_op(16'd7, 16'h0005, 16'd20, 16'h0006);
    fsourceID = 16'd7; fbatteryStat = 16'h0005; fValue = 16'd20; fclusterID = 16'h0006;
    wr_mark = wr_total;
    start = 1'b1;
    @(negedge clock);
    check_val("b2b first busy", {31'd0, busy}, 32'd1);
    wait_done("b2b first");
    @(negedge clock);
    check_val("b2b idle gap", {30'd0, busy, done}, 32'd0);
    wr_mark = wr_total;
    @(negedge clock);
    check_val("b2b second busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done("b2b second");
    @(negedge clock);
    compare_mem("b2b image");
    check_val("b2b queue drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
